// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 8-bit core: decodes IF/ID and drives the ID/EX controls,
// the PC/IF-ID enables, flush/bubble signals, EX-to-ID forwarding and stall/flush counters.
module pipe_hazard_ctrl #(
   parameter int unsigned MUL_LAT   = 3,
   parameter int unsigned FLUSH_CYC = 1,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [7:0]       id_inst,
   input  logic [2:0]       ex_rd,
   input  logic             ex_regwrite,
   output logic             pc_en,
   output logic             pc_src,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             ctl_regwrite,
   output logic             ctl_sel1,
   output logic             fwd_rs,
   output logic             fwd_rd,
   output logic             busy,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int unsigned MCNT_W = 4;
   localparam int unsigned FCNT_W = 2;

   localparam logic [1:0] OP_MOVI = 2'b00;
   localparam logic [1:0] OP_ADD  = 2'b01;
   localparam logic [1:0] OP_MUL  = 2'b10;
   localparam logic [1:0] OP_JMP  = 2'b11;

   typedef enum logic [1:0] {RUN, MULB, JFL} state_t;

   state_t              state_q, state_d;
   logic [MCNT_W-1:0]   mcnt_q, mcnt_d;
   logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
   logic                stall_inc, flush_inc;

   logic [1:0] op;
   logic [2:0] rd, rs;
   logic       reads_regs;

   assign op = id_inst[7:6];
   assign rd = id_inst[5:3];
   assign rs = id_inst[2:0];
   assign reads_regs = (op == OP_ADD) || (op == OP_MUL);

   // Forwarding is a pure read-port mux select; it never stalls the pipe.
   assign fwd_rs = reset & ex_regwrite & (ex_rd == rs) & id_valid & reads_regs;
   assign fwd_rd = reset & ex_regwrite & (ex_rd == rd) & id_valid & reads_regs;

   // Next-state and control decode.
   always_comb begin
      state_d      = state_q;
      mcnt_d       = mcnt_q;
      fcnt_d       = fcnt_q;
      pc_en        = 1'b0;
      pc_src       = 1'b1;
      ifid_en      = 1'b0;
      ifid_flush   = 1'b0;
      idex_bubble  = 1'b0;
      ctl_regwrite = 1'b0;
      ctl_sel1     = 1'b0;
      busy         = 1'b0;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;
      if (!reset) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else begin
         case (state_q)
            RUN: begin
               pc_en   = 1'b1;
               ifid_en = 1'b1;
               if (!id_valid) begin
                  idex_bubble = 1'b1;
               end else begin
                  case (op)
                     OP_MOVI: ctl_regwrite = 1'b1;
                     OP_ADD: begin
                        ctl_regwrite = 1'b1;
                        ctl_sel1     = 1'b1;
                     end
                     OP_MUL: begin
                        ctl_regwrite = 1'b1;
                        ctl_sel1     = 1'b1;
                        if (MUL_LAT > 1) begin
                           state_d = MULB;
                           mcnt_d  = MCNT_W'(MUL_LAT - 1);
                        end
                     end
                     OP_JMP: begin
                        pc_src     = 1'b0;
                        ifid_flush = 1'b1;
                        flush_inc  = 1'b1;
                        if (FLUSH_CYC > 1) begin
                           state_d = JFL;
                           fcnt_d  = FCNT_W'(FLUSH_CYC - 1);
                        end
                     end
                     default: ;
                  endcase
               end
            end
            MULB: begin
               idex_bubble = 1'b1;
               busy        = 1'b1;
               stall_inc   = 1'b1;
               mcnt_d      = mcnt_q - MCNT_W'(1);
               if (mcnt_q <= MCNT_W'(1)) state_d = RUN;
            end
            JFL: begin
               pc_en       = 1'b1;
               ifid_en     = 1'b1;
               ifid_flush  = 1'b1;
               idex_bubble = 1'b1;
               flush_inc   = 1'b1;
               fcnt_d      = fcnt_q - FCNT_W'(1);
               if (fcnt_q <= FCNT_W'(1)) state_d = RUN;
            end
            default: state_d = RUN;
         endcase
      end
   end

   // State and saturating performance counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= RUN;
         mcnt_q    <= '0;
         fcnt_q    <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state_q <= state_d;
         mcnt_q  <= mcnt_d;
         fcnt_q  <= fcnt_d;
         if (stall_inc && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush_inc && (flush_cnt != {CNT_W{1'b1}})) flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule
